seq_alu: RTL and testbench
==========================

# seq_alu

Registered, parametrised ALU with valid/ready handshakes on both sides and an iterative shift-add multiplier. It is the next generation of the team's 8-bit combinational ALU: same opcode map and flag semantics, now generic in `WIDTH`, with registered outputs, back-pressure and a multi-cycle MUL. It sits between an operand-issue stage (upstream) and a result-writeback stage (downstream).

## Interface
- `WIDTH`, default 8: operand width in bits, legal range 2 to 32. The result is `2*WIDTH` bits.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  an operation is presented.
- `in_ready`  output  1  the block can accept an operation this cycle.
- `op`  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 AND, 100 OR, 101 NAND, 110 NOR, 111 XOR.
- `operand_a`, `operand_b`  input  WIDTH  unsigned operands.
- `out_valid`  output  1  `result` and the flags are valid.
- `out_ready`  input  1  downstream consumes the result this cycle.
- `result`  output  2*WIDTH  registered result.
- `carry_flag`  output  1  carry out of ADD, or borrow out of SUB.
- `zero_flag`  output  1  high when `result` is all zeros.
- `busy`  output  1  high while a MUL is iterating.

## Operation
- FSM states:
  - IDLE: no result is held.
  - MUL_RUN: iterating a multiply.
  - HOLD: a result is waiting to be consumed.
- `in_ready` = (IDLE) or (HOLD and `out_ready`). It is low throughout MUL_RUN.
- An operation is accepted on a rising edge where `in_valid` and `in_ready` are both high.
- Non-MUL accept:
  - `result`, `carry_flag` and `zero_flag` are registered on the accepting edge.
  - The state goes to HOLD.
- ADD / SUB:
  - `result[WIDTH-1:0]` = (A+B) or (A−B) mod 2^WIDTH. The upper WIDTH bits are 0.
  - `carry_flag` = bit WIDTH of the (WIDTH+1)-bit sum. For SUB it is the borrow, i.e. 1 when A<B.
- Logic ops:
  - Operate bitwise on WIDTH bits. The result is zero-extended.
  - NAND and NOR invert only the low WIDTH bits.
  - `carry_flag` is 0.
- MUL:
  - The accepting edge loads A, B, accumulator = 0 and count = 0, and enters MUL_RUN. `busy` goes high.
  - Each following edge performs one step: if the current multiplier LSB is 1, add the shifted multiplicand; then shift.
  - After WIDTH steps, `result` gets the full 2*WIDTH product, `carry_flag` is 0, and the state goes to HOLD.
- `zero_flag` = (`result` == 0) and is computed on the value being registered.
- `out_valid` is high exactly in HOLD.
- While `out_valid` is high and `out_ready` is low, `result` and the flags hold stable.
- HOLD with `out_ready` high:
  - With a simultaneous accept: a non-MUL op stays in HOLD with the new result, and `out_valid` stays high. A MUL op goes to MUL_RUN, and `out_valid` drops.
  - With no accept: the state goes to IDLE.
- Outside HOLD, `result` and the flags retain their last value.
- All 8 opcodes are decoded. There is no illegal encoding.

## Timing
- Reset values: state IDLE, `result` 0, `carry_flag` 0, `zero_flag` 0, `out_valid` 0, `busy` 0, `in_ready` 1. All internal registers are 0.
- Reset asserted at any time, including mid-MUL, aborts immediately to these values. No result is produced for the aborted operation.
- Latency:
  - Non-MUL: `out_valid` is high in the cycle after the accepting edge.
  - MUL: `out_valid` rises on the WIDTH-th edge after the accepting edge.
- Throughput:
  - Non-MUL: one result per cycle while `out_ready` is held high.
  - MUL: one per WIDTH+1 cycles.
- Inputs are sampled only on the accepting edge. Changes to `operand_a`/`operand_b`/`op` during MUL_RUN have no effect.

## Configuration
- `SEQ_ALU_FAST_MUL_EN` defined:
  - MUL is computed combinationally as A*B and registered on the accepting edge, like every other op.
  - MUL_RUN is never entered and `busy` is tied 0.
  - MUL latency is 1 and `in_ready` follows the non-MUL rule.
- Not defined: the iterative WIDTH-cycle shift-add multiplier described above.
- Results, flags and handshake ordering are identical in both builds. Only MUL latency and `in_ready` gaps differ.

## Test plan
All scenarios use WIDTH=8.
1. ADD 0xFF+0x01, `out_ready`=1 → next cycle `result`=0x0000, `carry_flag`=1, `zero_flag`=1, `out_valid`=1.
2. SUB 0x05−0x07 → `result`=0x00FE, `carry_flag`=1, `zero_flag`=0. Then SUB 0x07−0x07 → `result`=0x0000, `carry_flag`=0, `zero_flag`=1.
3. MUL 0xFF×0xFF → `busy`=1 and `in_ready`=0 for 8 cycles; `out_valid` rises on the 8th edge after accept with `result`=0xFE01 and `zero_flag`=0. With `SEQ_ALU_FAST_MUL_EN` defined, the same result arrives the next cycle.
4. Back-pressure: AND 0xF0&0x3C, then hold `out_ready`=0 for 5 cycles → `result`=0x0030 stable, `in_ready`=0. Raise `out_ready` together with `in_valid` carrying XOR 0xAA^0xAA → the next cycle shows `result`=0x0000, `zero_flag`=1, `out_valid` still 1.
5. Streaming: 4 back-to-back NAND/NOR/OR/XOR ops with `out_ready`=1 → 4 results on 4 consecutive cycles. NAND 0x00,0x00 gives 0x00FF.
6. Reset mid-MUL: assert `rst_n`=0 on the 3rd iteration cycle → all outputs 0 and `in_ready`=1. After release, an ADD 0x01+0x02 gives 0x0003 one cycle after accept.

Source files
------------

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- registered, parametrised ALU with valid/ready handshakes and an
// iterative shift-add multiplier.
//
// Eight opcodes: ADD, SUB, MUL, AND, OR, NAND, NOR, XOR. The result is
// 2*WIDTH bits, and the flags are registered together with it.
//
// Build option:
//   SEQ_ALU_FAST_MUL_EN  When defined, MUL is a single-cycle combinational
//                        A*B, and the iterative multiplier is removed.
//                        When undefined, MUL takes WIDTH cycles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (op, operand_a, operand_b)
//   op [2:0]              opcode
//   operand_a/b [WIDTH]   unsigned operands
//   out_valid / out_ready downstream handshake
//   result [2*WIDTH]      registered result
//   carry_flag            carry out of ADD, borrow out of SUB
//   zero_flag             result == 0
//   busy                  a MUL is iterating
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [WIDTH-1:0]     operand_a,
  input  logic [WIDTH-1:0]     operand_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 carry_flag,
  output logic                 zero_flag,
  output logic                 busy
);

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_XOR  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_HOLD    = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [2*WIDTH-1:0] r_result;
  logic               r_carry;
  logic               r_zero;

  op_e                w_op;
  logic               w_accept;
  logic               w_iter_mul;   // accepted op goes to the multi-cycle path
  logic               w_mul_done;   // final multiplier step this cycle
  logic [2*WIDTH-1:0] w_acc_next;   // accumulator after the current step
  logic [2*WIDTH-1:0] w_alu_res;
  logic               w_alu_carry;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;

  assign w_op     = op_e'(op);
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Single-cycle datapath. Bit WIDTH of the widened difference is the borrow.
  // --------------------------------------------------------------------------
  assign w_sum  = {1'b0, operand_a} + {1'b0, operand_b};
  assign w_diff = {1'b0, operand_a} - {1'b0, operand_b};

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    w_alu_res   = '0;
    w_alu_carry = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_alu_res   = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
        w_alu_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_res   = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
        w_alu_carry = w_diff[WIDTH];
      end
`ifdef SEQ_ALU_FAST_MUL_EN
      OP_MUL:  w_alu_res = {{WIDTH{1'b0}}, operand_a} * {{WIDTH{1'b0}}, operand_b};
`else
      OP_MUL:  w_alu_res = '0;  // handled by the iterative multiplier
`endif
      OP_AND:  w_alu_res = {{WIDTH{1'b0}}, operand_a & operand_b};
      OP_OR:   w_alu_res = {{WIDTH{1'b0}}, operand_a | operand_b};
      OP_NAND: w_alu_res = {{WIDTH{1'b0}}, ~(operand_a & operand_b)};
      OP_NOR:  w_alu_res = {{WIDTH{1'b0}}, ~(operand_a | operand_b)};
      OP_XOR:  w_alu_res = {{WIDTH{1'b0}}, operand_a ^ operand_b};
      default: w_alu_res = '0;
    endcase
  end

`ifdef SEQ_ALU_FAST_MUL_EN
  assign w_iter_mul = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_acc_next = '0;
`else
  // --------------------------------------------------------------------------
  // Iterative shift-add multiplier: one multiplier bit per cycle, LSB first.
  // --------------------------------------------------------------------------
  localparam int              CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] w_addend;

  assign w_iter_mul = w_accept && (w_op == OP_MUL);
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;
  assign w_mul_done = (r_state == S_MUL_RUN) && (r_count == LAST_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all sequential state, so every
      // register samples pre-edge values regardless of statement order.
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_iter_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, operand_a};
      r_mplier <= operand_b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == S_MUL_RUN) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 1'b1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Result and flag registers. They change only on a non-MUL accept or on the
  // final multiplier step, and otherwise hold their last value.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_accept && !w_iter_mul) begin
      r_result <= w_alu_res;
      r_carry  <= w_alu_carry;
      r_zero   <= (w_alu_res == '0);
    end else if (w_mul_done) begin
      r_result <= w_acc_next;
      r_carry  <= 1'b0;
      r_zero   <= (w_acc_next == '0);
    end
  end

  assign result     = r_result;
  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;

  // --------------------------------------------------------------------------
  // Control FSM: state register, next-state logic, output logic.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = w_iter_mul ? S_MUL_RUN : S_HOLD;
      end
      S_MUL_RUN: begin
        if (w_mul_done) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (w_accept)       w_state_next = w_iter_mul ? S_MUL_RUN : S_HOLD;
        else if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
    out_valid = (r_state == S_HOLD);
`ifdef SEQ_ALU_FAST_MUL_EN
    busy      = 1'b0;
`else
    busy      = (r_state == S_MUL_RUN);
`endif
  end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu -- self-checking bench for seq_alu (WIDTH = 8).
// A table of vectors is streamed through the DUT. Expected results go into a
// scoreboard queue at accept time, and a monitor pops and compares each one
// when the DUT hands it downstream. Hand-written sequences cover the MUL
// latency, back-pressure, streaming and reset-mid-MUL cases.
// -----------------------------------------------------------------------------
module tb_seq_alu;

  localparam int W = 8;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, AND_ = 3'b011,
                         OR_ = 3'b100, NAND_ = 3'b101, NOR_ = 3'b110, XOR_ = 3'b111;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2:0]     op_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           carry_flag;
  logic           zero_flag;
  logic           busy;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op_i),
    .operand_a  (a_i),
    .operand_b  (b_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] res;
    logic           c;
    logic           z;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] res;
    logic           c;
    logic           z;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[18];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one op, wait (bounded) for in_ready, record the expectation and
  // return at the falling edge just after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] r, input logic c, input logic z);
    int n;
    exp_t e;
    op_i = o; a_i = a; b_i = b; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check("accept", 32'(in_ready), 32'd1);
    if (in_ready) begin
      e.res = r; e.c = c; e.z = z;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compare each result as it is consumed downstream.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_result", 32'(result), 32'(e.res));
        check("sb_carry", 32'(carry_flag), 32'(e.c));
        check("sb_zero", 32'(zero_flag), 32'(e.z));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{ADD,   8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1};
    vecs[1]  = '{SUB,   8'h05, 8'h07, 16'h00FE, 1'b1, 1'b0};
    vecs[2]  = '{SUB,   8'h07, 8'h07, 16'h0000, 1'b0, 1'b1};
    vecs[3]  = '{ADD,   8'h12, 8'h34, 16'h0046, 1'b0, 1'b0};
    vecs[4]  = '{AND_,  8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0};
    vecs[5]  = '{OR_,   8'h0F, 8'h30, 16'h003F, 1'b0, 1'b0};
    vecs[6]  = '{NAND_, 8'h00, 8'h00, 16'h00FF, 1'b0, 1'b0};
    vecs[7]  = '{NOR_,  8'hFF, 8'h00, 16'h0000, 1'b0, 1'b1};
    vecs[8]  = '{XOR_,  8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0};
    vecs[9]  = '{XOR_,  8'hAA, 8'hAA, 16'h0000, 1'b0, 1'b1};
    vecs[10] = '{MUL,   8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0};
    vecs[11] = '{MUL,   8'h00, 8'h37, 16'h0000, 1'b0, 1'b1};
    vecs[12] = '{MUL,   8'h0D, 8'h0B, 16'h008F, 1'b0, 1'b0};
    vecs[13] = '{SUB,   8'h00, 8'h01, 16'h00FF, 1'b1, 1'b0};
    vecs[14] = '{NAND_, 8'hF0, 8'h0F, 16'h00FF, 1'b0, 1'b0};
    vecs[15] = '{NOR_,  8'h0F, 8'h30, 16'h00C0, 1'b0, 1'b0};
    vecs[16] = '{MUL,   8'h80, 8'h02, 16'h0100, 1'b0, 1'b0};
    vecs[17] = '{ADD,   8'h80, 8'h80, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_i = '0; a_i = '0; b_i = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_flag), 32'd0);
    check("rst_zero", 32'(zero_flag), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with carry-out, one-cycle latency
    send(ADD, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b1);
    #1;
    check("add_lat_valid", 32'(out_valid), 32'd1);
    check("add_lat_result", 32'(result), 32'h0000);
    check("add_lat_carry", 32'(carry_flag), 32'd1);
    check("add_lat_zero", 32'(zero_flag), 32'd1);
    drain();

    // MUL latency; operands are scrambled during the run and must be ignored
    send(MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0);
    op_i = ADD; a_i = 8'h00; b_i = 8'h00;
`ifdef SEQ_ALU_FAST_MUL_EN
    #1;
    check("mul_fast_valid", 32'(out_valid), 32'd1);
    check("mul_fast_busy", 32'(busy), 32'd0);
`else
    for (int i = 0; i < W; i++) begin
      #1;
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_in_ready", 32'(in_ready), 32'd0);
      check("mul_out_valid_low", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    #1;
    check("mul_done_valid", 32'(out_valid), 32'd1);
    check("mul_done_busy", 32'(busy), 32'd0);
`endif
    check("mul_result", 32'(result), 32'hFE01);
    check("mul_zero", 32'(zero_flag), 32'd0);
    drain();

    // Back-pressure: result holds, then a simultaneous consume + accept
    out_ready = 1'b0;
    send(AND_, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_result", 32'(result), 32'h0030);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(XOR_, 8'hAA, 8'hAA, 16'h0000, 1'b0, 1'b1);
    #1;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_result", 32'(result), 32'h0000);
    check("bp_next_zero", 32'(zero_flag), 32'd1);
    drain();

    // Streaming: four results on four consecutive cycles
    send(NAND_, 8'h00, 8'h00, 16'h00FF, 1'b0, 1'b0);
    #1 check("stream_valid0", 32'(out_valid), 32'd1);
    check("stream_nand", 32'(result), 32'h00FF);
    send(NOR_, 8'h0F, 8'h30, 16'h00C0, 1'b0, 1'b0);
    #1 check("stream_valid1", 32'(out_valid), 32'd1);
    send(OR_, 8'h0F, 8'h30, 16'h003F, 1'b0, 1'b0);
    #1 check("stream_valid2", 32'(out_valid), 32'd1);
    send(XOR_, 8'hAA, 8'h55, 16'h00FF, 1'b0, 1'b0);
    #1 check("stream_valid3", 32'(out_valid), 32'd1);
    drain();

    // Table of vectors, streamed back to back
    for (int i = 0; i < 18; i++)
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c, vecs[i].z);
    drain();

    // Reset mid-MUL: leave a nonzero result with carry set, then abort a MUL
    send(SUB, 8'h00, 8'h01, 16'h00FF, 1'b1, 1'b0);
    drain();
    out_ready = 1'b0;
    send(MUL, 8'h03, 8'h05, 16'h000F, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    void'(sb.pop_back());  // the aborted MUL never produces a result
    #1;
    check("abort_result", 32'(result), 32'd0);
    check("abort_carry", 32'(carry_flag), 32'd0);
    check("abort_zero", 32'(zero_flag), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send(ADD, 8'h01, 8'h02, 16'h0003, 1'b0, 1'b0);
    #1;
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_result", 32'(result), 32'h0003);
    drain();

    repeat (3) @(negedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
